// File: rtl/afe_emu_pkg.sv
// afe_emu_pkg
// Shared types, datapath widths and the ADC clamp helper for the
// pulse-oximeter analog front-end emulator.
//   pulse_state_t : phases of the synthetic heartbeat (RISE, FALL, REST)
//   PD_W / C_W / A_W : widths of photodiode sum, compensated and gained values
//   clamp_u8 : signed gained value -> 8-bit ADC code centred on 128
package afe_emu_pkg;

    typedef enum logic [1:0] {
        RISE = 2'd0,
        FALL = 2'd1,
        REST = 2'd2
    } pulse_state_t;

    localparam int PD_W = 14;
    localparam int C_W  = 15;
    localparam int A_W  = 20;

    localparam logic signed [A_W:0] ADC_MID = 21'sd128;
    localparam logic signed [A_W:0] ADC_TOP = 21'sd255;

    // Offset by mid-scale and saturate at both rails; one extra bit keeps
    // the offset addition from overflowing.
    function automatic logic [7:0] clamp_u8(input logic signed [A_W-1:0] a);
        logic signed [A_W:0] s;
        s = $signed({a[A_W-1], a}) + ADC_MID;
        if (s[A_W]) begin
            clamp_u8 = 8'd0;
        end else if (s > ADC_TOP) begin
            clamp_u8 = 8'd255;
        end else begin
            clamp_u8 = s[7:0];
        end
    endfunction

endpackage

// File: rtl/afe_emulator_ppg.sv
// ppg_pulse_gen
// Synthetic heartbeat waveform generator.
//   CLK  : system clock
//   rst  : synchronous active-high reset
//   w    : 8-bit waveform sample (ramp up 256 cycles, ramp down 510 cycles,
//          flat zero for REST_CYCLES cycles)
//   BEAT : high during the first cycle of each pulse (RISE, w = 0)
// While in reset the outputs read 0; the first cycle after reset release
// presents RISE k = 0 with BEAT high. The armed flag provides that one-cycle
// entry so that w/BEAT stay registered.
module ppg_pulse_gen
    import afe_emu_pkg::*;
#(
    parameter int REST_CYCLES = 234
) (
    input  logic       CLK,
    input  logic       rst,
    output logic [7:0] w,
    output logic       BEAT
);

    localparam logic [15:0] REST_LAST = 16'(REST_CYCLES - 1);

    pulse_state_t state_r;
    logic [15:0]  k_r;
    logic         armed_r;
    logic [7:0]   w_r;
    logic         beat_r;

    // Pulse FSM; w_r/beat_r are loaded with the values of the position being entered.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_r <= RISE;
            k_r     <= 16'd0;
            armed_r <= 1'b0;
            w_r     <= 8'd0;
            beat_r  <= 1'b0;
        end else if (!armed_r) begin
            state_r <= RISE;
            k_r     <= 16'd0;
            armed_r <= 1'b1;
            w_r     <= 8'd0;
            beat_r  <= 1'b1;
        end else begin
            case (state_r)
                RISE: begin
                    beat_r <= 1'b0;
                    if (k_r == 16'd255) begin
                        state_r <= FALL;
                        k_r     <= 16'd0;
                        w_r     <= 8'd255;
                    end else begin
                        k_r <= k_r + 16'd1;
                        w_r <= k_r[7:0] + 8'd1;
                    end
                end
                FALL: begin
                    beat_r <= 1'b0;
                    if (k_r == 16'd509) begin
                        state_r <= REST;
                        k_r     <= 16'd0;
                        w_r     <= 8'd0;
                    end else begin
                        // entering k+1: w = 255 - ((k+1)+1)/2
                        k_r <= k_r + 16'd1;
                        w_r <= 8'd255 - 8'((k_r + 16'd2) >> 1);
                    end
                end
                REST: begin
                    w_r <= 8'd0;
                    if (k_r == REST_LAST) begin
                        state_r <= RISE;
                        k_r     <= 16'd0;
                        beat_r  <= 1'b1;
                    end else begin
                        k_r    <= k_r + 16'd1;
                        beat_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= RISE;
                    k_r     <= 16'd0;
                    w_r     <= 8'd0;
                    beat_r  <= 1'b1;
                end
            endcase
        end
    end

    assign w    = w_r;
    assign BEAT = beat_r;

endmodule

// File: rtl/afe_emulator.sv
// afe_emulator
// Responder-side model of the photodiode / PGA / ADC chain.
//   CLK, rst            : clock, synchronous active-high reset
//   LED_DRIVE[3:0]      : LED current code
//   LED_RED, LED_IR     : LED enables
//   DC_Comp[6:0]        : DC compensation code (COMP_LSB counts per LSB)
//   PGA_Gain[3:0]       : PGA code, linear gain PGA_Gain+1
//   ADC[7:0]            : converted sample, 128 in reset
//   ADC_strobe          : one-cycle pulse after each ADC load
//   BEAT                : first cycle of each synthetic pulse
// Pipeline: S1 = pd (with the DC_Comp/PGA_Gain codes of the same cycle),
// S2 = gained value a, S3 = ADC register loaded on the divider terminal count.
module afe_emulator
    import afe_emu_pkg::*;
#(
    parameter int AMBIENT      = 16,
    parameter int DC_RED       = 40,
    parameter int DC_IR        = 50,
    parameter int AC_SHIFT_RED = 6,
    parameter int AC_SHIFT_IR  = 5,
    parameter int COMP_LSB     = 4,
    parameter int REST_CYCLES  = 234,
    parameter int SAMPLE_DIV   = 1
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic [3:0] LED_DRIVE,
    input  logic       LED_RED,
    input  logic       LED_IR,
    input  logic [6:0] DC_Comp,
    input  logic [3:0] PGA_Gain,
    output logic [7:0] ADC,
    output logic       ADC_strobe,
    output logic       BEAT
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

    logic [7:0]              w_s;
    logic                    beat_s;
    logic [PD_W-1:0]         drive_s;
    logic [PD_W-1:0]         red_s;
    logic [PD_W-1:0]         ir_s;
    logic [PD_W-1:0]         pd_s;
    logic [C_W-1:0]          comp_cnt_s;
    logic signed [C_W-1:0]   c_s;
    logic signed [A_W-1:0]   c_ext_s;
    logic signed [A_W-1:0]   gain_ext_s;
    logic signed [A_W-1:0]   a_s;

    logic [PD_W-1:0]         pd_r;
    logic [6:0]              comp_r;
    logic [3:0]              gain_r;
    logic signed [A_W-1:0]   a_r;
    logic                    v1_r;
    logic                    v2_r;
    logic [DIV_W-1:0]        div_r;
    logic [7:0]              adc_r;
    logic                    strobe_r;

    ppg_pulse_gen #(
        .REST_CYCLES(REST_CYCLES)
    ) u_ppg (
        .CLK (CLK),
        .rst (rst),
        .w   (w_s),
        .BEAT(beat_s)
    );

    // Photodiode sum: ambient plus DC and AC contributions of each enabled LED.
    always_comb begin
        drive_s = PD_W'(LED_DRIVE);
        red_s   = drive_s * PD_W'(DC_RED) + ((PD_W'(w_s) * drive_s) >> AC_SHIFT_RED);
        ir_s    = drive_s * PD_W'(DC_IR) + ((PD_W'(w_s) * drive_s) >> AC_SHIFT_IR);
        pd_s    = PD_W'(AMBIENT);
        if (LED_RED) begin
            pd_s = pd_s + red_s;
        end else begin
            pd_s = pd_s;
        end
        if (LED_IR) begin
            pd_s = pd_s + ir_s;
        end else begin
            pd_s = pd_s;
        end
    end

    // DC compensation and PGA gain on the S1 values; widths leave headroom so nothing wraps.
    always_comb begin
        comp_cnt_s = C_W'(comp_r) * C_W'(COMP_LSB);
        c_s        = $signed({1'b0, pd_r}) - $signed(comp_cnt_s);
        c_ext_s    = {{(A_W-C_W){c_s[C_W-1]}}, c_s};
        gain_ext_s = {{(A_W-5){1'b0}}, ({1'b0, gain_r} + 5'd1)};
        a_s        = c_ext_s * gain_ext_s;
    end

    // S1/S2 pipeline with fill flags; reset leaves the equivalent of c = 0.
    always_ff @(posedge CLK) begin
        if (rst) begin
            pd_r   <= {PD_W{1'b0}};
            comp_r <= 7'd0;
            gain_r <= 4'd0;
            a_r    <= {A_W{1'b0}};
            v1_r   <= 1'b0;
            v2_r   <= 1'b0;
        end else begin
            pd_r   <= pd_s;
            comp_r <= DC_Comp;
            gain_r <= PGA_Gain;
            a_r    <= a_s;
            v1_r   <= 1'b1;
            v2_r   <= v1_r;
        end
    end

    // Sample divider and S3 ADC register; loads only once S2 holds real data.
    always_ff @(posedge CLK) begin
        if (rst) begin
            div_r    <= {DIV_W{1'b0}};
            adc_r    <= 8'd128;
            strobe_r <= 1'b0;
        end else begin
            if (div_r == DIV_LAST) begin
                div_r <= {DIV_W{1'b0}};
            end else begin
                div_r <= div_r + DIV_W'(1);
            end
            if ((div_r == DIV_LAST) && v2_r) begin
                adc_r    <= clamp_u8(a_r);
                strobe_r <= 1'b1;
            end else begin
                strobe_r <= 1'b0;
            end
        end
    end

    assign ADC        = adc_r;
    assign ADC_strobe = strobe_r;
    assign BEAT       = beat_s;

endmodule
